// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if : data-memory request/acknowledge bus used by mem_stage.
//
// Signals
//   dmem_req   : access request, held high until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : byte address of the access
//   dmem_wdata : store data
//   dmem_rdata : load data, valid in the cycle dmem_ack is high
//   dmem_ack   : access completion strobe
//
// Modports
//   master : the pipeline stage that issues requests
//   slave  : the memory that answers them
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : MEM pipeline stage with a two-state (IDLE/ACCESS) data-memory
// handshake FSM and the MEM/WB pipeline register.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   iInstr .. iPC       : EX/MEM register contents (control, ALU result,
//                         store data, branch target, PC values)
//   dmem                : data-memory bus (mem_stage_if.master)
//   stall               : holds the EX/MEM register while an access is pending
//   pcsrc, pcTarget     : fetch redirect strobe and address
//   omisalign           : one-cycle pulse on a misaligned access
//   oInstr .. owriteRegWire : MEM/WB register contents
//
// Build option
//   MEM_ALIGN_CHECK_EN : when defined, an access with a non-word-aligned
//   address is not issued; it retires immediately with register write
//   suppressed and omisalign pulsed. When undefined, addresses pass through
//   unchanged and omisalign stays 0.
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  // EX/MEM side
  input  logic [31:0] iInstr,
  input  logic        iRegWrite,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iMemToReg,
  input  logic        iBranch,
  input  logic        iinvertzero,
  input  logic        iJump,
  input  logic        iZero,
  input  logic        ivalid,
  input  logic [31:0] iB,
  input  logic [31:0] iResult,
  input  logic [31:0] inextPCBranch,
  input  logic [31:0] iNPC1,
  input  logic [31:0] iPC,
  input  logic [4:0]  iwriteRegWire,
  // data memory
  mem_stage_if.master dmem,
  // control
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pcTarget,
  output logic        omisalign,
  // MEM/WB side
  output logic [31:0] oInstr,
  output logic [31:0] oReadData,
  output logic [31:0] oResult,
  output logic [31:0] oNPC1,
  output logic [31:0] oPC,
  output logic        oRegWrite,
  output logic        oMemToReg,
  output logic        ovalid,
  output logic [4:0]  owriteRegWire
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e      state_q;

  // Bus registers
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Copy of the instruction held while the access is outstanding
  logic [31:0] instr_l_q;
  logic [31:0] result_l_q;
  logic [31:0] npc1_l_q;
  logic [31:0] pc_l_q;
  logic        regwrite_l_q;
  logic        memtoreg_l_q;
  logic [4:0]  wreg_l_q;

  // MEM/WB registers
  logic [31:0] instr_q;
  logic [31:0] readdata_q;
  logic [31:0] result_q;
  logic [31:0] npc1_q;
  logic [31:0] pc_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic        valid_q;
  logic [4:0]  wreg_q;
  logic        misalign_q;

  logic        access_s;
  logic        misalign_s;
  logic        start_s;
  logic        stall_s;
  logic        pcsrc_s;

  assign access_s = ivalid & (iMemRead | iMemWrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = access_s & (iResult[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // A misaligned access is retired in place instead of being issued.
  assign start_s = access_s & ~misalign_s;

  // Stall and redirect are combinational so the EX/MEM register and fetch
  // react in the same cycle; a redirect is never taken during an access.
  always_comb begin
    stall_s = 1'b0;
    pcsrc_s = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = start_s;
        pcsrc_s = ivalid & (iJump | (iBranch & (iZero ^ iinvertzero)));
      end
      ACCESS: begin
        stall_s = ~dmem.dmem_ack;
        pcsrc_s = 1'b0;
      end
      default: begin
        stall_s = 1'b0;
        pcsrc_s = 1'b0;
      end
    endcase
  end

  // Handshake FSM, bus registers and MEM/WB register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      instr_l_q    <= 32'h0000_0000;
      result_l_q   <= 32'h0000_0000;
      npc1_l_q     <= 32'h0000_0000;
      pc_l_q       <= 32'h0000_0000;
      regwrite_l_q <= 1'b0;
      memtoreg_l_q <= 1'b0;
      wreg_l_q     <= 5'd0;
      instr_q      <= 32'h0000_0000;
      readdata_q   <= 32'h0000_0000;
      result_q     <= 32'h0000_0000;
      npc1_q       <= 32'h0000_0000;
      pc_q         <= 32'h0000_0000;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      valid_q      <= 1'b0;
      wreg_q       <= 5'd0;
      misalign_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q      <= ACCESS;
            req_q        <= 1'b1;
            // Read+write together is treated as a write.
            we_q         <= iMemWrite;
            addr_q       <= iResult;
            wdata_q      <= iB;
            instr_l_q    <= iInstr;
            result_l_q   <= iResult;
            npc1_l_q     <= iNPC1;
            pc_l_q       <= iPC;
            regwrite_l_q <= iRegWrite;
            memtoreg_l_q <= iMemToReg;
            wreg_l_q     <= iwriteRegWire;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
          end else begin
            instr_q      <= iInstr;
            readdata_q   <= 32'h0000_0000;
            result_q     <= iResult;
            npc1_q       <= iNPC1;
            pc_q         <= iPC;
            regwrite_q   <= iRegWrite & ~misalign_s;
            memtoreg_q   <= iMemToReg;
            wreg_q       <= iwriteRegWire;
            valid_q      <= ivalid;
            misalign_q   <= misalign_s;
          end
        end
        ACCESS: begin
          misalign_q <= 1'b0;
          if (dmem.dmem_ack) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            instr_q    <= instr_l_q;
            readdata_q <= we_q ? 32'h0000_0000 : dmem.dmem_rdata;
            result_q   <= result_l_q;
            npc1_q     <= npc1_l_q;
            pc_q       <= pc_l_q;
            regwrite_q <= regwrite_l_q;
            memtoreg_q <= memtoreg_l_q;
            wreg_q     <= wreg_l_q;
            valid_q    <= 1'b1;
          end else begin
            // Bubble into WB while the memory is busy.
            valid_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          req_q      <= 1'b0;
          we_q       <= 1'b0;
          addr_q     <= 32'h0000_0000;
          wdata_q    <= 32'h0000_0000;
          valid_q    <= 1'b0;
          regwrite_q <= 1'b0;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign stall         = stall_s;
  assign pcsrc         = pcsrc_s;
  assign pcTarget      = inextPCBranch;
  assign omisalign     = misalign_q;

  assign oInstr        = instr_q;
  assign oReadData     = readdata_q;
  assign oResult       = result_q;
  assign oNPC1         = npc1_q;
  assign oPC           = pc_q;
  assign oRegWrite     = regwrite_q;
  assign oMemToReg     = memtoreg_q;
  assign ovalid        = valid_q;
  assign owriteRegWire = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clock;
  logic        reset;
  logic [31:0] iInstr;
  logic        iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranch;
  logic        iinvertzero, iJump, iZero, ivalid;
  logic [31:0] iB, iResult, inextPCBranch, iNPC1, iPC;
  logic [4:0]  iwriteRegWire;
  logic        stall, pcsrc, omisalign;
  logic [31:0] pcTarget;
  logic [31:0] oInstr, oReadData, oResult, oNPC1, oPC;
  logic        oRegWrite, oMemToReg, ovalid;
  logic [4:0]  owriteRegWire;

  int checks;
  int errors;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clock         (clock),
    .reset         (reset),
    .iInstr        (iInstr),
    .iRegWrite     (iRegWrite),
    .iMemRead      (iMemRead),
    .iMemWrite     (iMemWrite),
    .iMemToReg     (iMemToReg),
    .iBranch       (iBranch),
    .iinvertzero   (iinvertzero),
    .iJump         (iJump),
    .iZero         (iZero),
    .ivalid        (ivalid),
    .iB            (iB),
    .iResult       (iResult),
    .inextPCBranch (inextPCBranch),
    .iNPC1         (iNPC1),
    .iPC           (iPC),
    .iwriteRegWire (iwriteRegWire),
    .dmem          (dmem_bus.master),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .pcTarget      (pcTarget),
    .omisalign     (omisalign),
    .oInstr        (oInstr),
    .oReadData     (oReadData),
    .oResult       (oResult),
    .oNPC1         (oNPC1),
    .oPC           (oPC),
    .oRegWrite     (oRegWrite),
    .oMemToReg     (oMemToReg),
    .ovalid        (ovalid),
    .owriteRegWire (owriteRegWire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    iInstr = 32'h0; iRegWrite = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
    iMemToReg = 1'b0; iBranch = 1'b0; iinvertzero = 1'b0; iJump = 1'b0;
    iZero = 1'b0; ivalid = 1'b0; iB = 32'h0; iResult = 32'h0;
    inextPCBranch = 32'h0; iNPC1 = 32'h0; iPC = 32'h0; iwriteRegWire = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    step();
    step();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %h exp %h", ovalid, 1'b0); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %h exp %h", oRegWrite, 1'b0); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    checks++; if (omisalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h exp %h", omisalign, 1'b0); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    ivalid = 1'b1; iRegWrite = 1'b1; iResult = 32'h0000_1234; iInstr = 32'h0011_2233;
    iwriteRegWire = 5'd5; iPC = 32'h0000_0010; iNPC1 = 32'h0000_0014;
    @(negedge clock);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %h exp %h", stall, 1'b0); end
    step();
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL alu_ovalid got %h exp %h", ovalid, 1'b1); end
    checks++; if (oResult !== 32'h0000_1234) begin errors++; $display("FAIL alu_result got %h exp %h", oResult, 32'h0000_1234); end
    checks++; if (owriteRegWire !== 5'd5) begin errors++; $display("FAIL alu_wreg got %h exp %h", owriteRegWire, 5'd5); end
    checks++; if (oPC !== 32'h0000_0010) begin errors++; $display("FAIL alu_pc got %h exp %h", oPC, 32'h0000_0010); end
    checks++; if (oReadData !== 32'h0) begin errors++; $display("FAIL alu_rdata got %h exp %h", oReadData, 32'h0); end
    ivalid = 1'b0;
    step();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL alu_invalid got %h exp %h", ovalid, 1'b0); end
    clear_inputs();
  endtask

  task automatic test_load();
    int stall_cnt;
    stall_cnt = 0;
    ivalid = 1'b1; iMemRead = 1'b1; iRegWrite = 1'b1; iMemToReg = 1'b1;
    iResult = 32'h0000_0100; iwriteRegWire = 5'd7; iJump = 1'b1;
    @(negedge clock);
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_idle got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    if (stall === 1'b1) stall_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL load_req got %h exp %h", dmem_bus.dmem_req, 1'b1); end
      checks++; if (dmem_bus.dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL load_addr got %h exp %h", dmem_bus.dmem_addr, 32'h0000_0100); end
      checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL load_bubble got %h exp %h", ovalid, 1'b0); end
      checks++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL load_pcsrc got %h exp %h", pcsrc, 1'b0); end
      if (stall === 1'b1) stall_cnt++;
      step();
    end
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_stall_ack got %h exp %h", stall, 1'b0); end
    checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL load_stall_cnt got %0d exp %0d", stall_cnt, 4); end
    step();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL load_ovalid got %h exp %h", ovalid, 1'b1); end
    checks++; if (oReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp %h", oReadData, 32'hDEAD_BEEF); end
    checks++; if (owriteRegWire !== 5'd7) begin errors++; $display("FAIL load_wreg got %h exp %h", owriteRegWire, 5'd7); end
    checks++; if (oMemToReg !== 1'b1) begin errors++; $display("FAIL load_memtoreg got %h exp %h", oMemToReg, 1'b1); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_done got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    step();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL load_single got %h exp %h", ovalid, 1'b0); end
  endtask

  task automatic test_store_back_to_back();
    ivalid = 1'b1; iMemWrite = 1'b1; iResult = 32'h0000_0020; iB = 32'h0000_55AA;
    @(negedge clock);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_stall got %h exp %h", stall, 1'b1); end
    step();
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h1234_5678;
    @(negedge clock);
    checks++; if (dmem_bus.dmem_we !== 1'b1) begin errors++; $display("FAIL store_we got %h exp %h", dmem_bus.dmem_we, 1'b1); end
    checks++; if (dmem_bus.dmem_wdata !== 32'h0000_55AA) begin errors++; $display("FAIL store_wdata got %h exp %h", dmem_bus.dmem_wdata, 32'h0000_55AA); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall_ack got %h exp %h", stall, 1'b0); end
    step();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    ivalid = 1'b1; iRegWrite = 1'b1; iResult = 32'h0000_0077;
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL store_ovalid got %h exp %h", ovalid, 1'b1); end
    checks++; if (oReadData !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp %h", oReadData, 32'h0); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL store_req_done got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    @(negedge clock);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %h exp %h", stall, 1'b0); end
    step();
    checks++; if (oResult !== 32'h0000_0077) begin errors++; $display("FAIL b2b_result got %h exp %h", oResult, 32'h0000_0077); end
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL b2b_ovalid got %h exp %h", ovalid, 1'b1); end
    clear_inputs();
    step();
  endtask

  task automatic test_rw_both();
    ivalid = 1'b1; iMemRead = 1'b1; iMemWrite = 1'b1; iResult = 32'h0000_0044; iB = 32'h0000_0099;
    step();
    @(negedge clock);
    checks++; if (dmem_bus.dmem_we !== 1'b1) begin errors++; $display("FAIL rw_we got %h exp %h", dmem_bus.dmem_we, 1'b1); end
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h0000_AAAA;
    step();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (oReadData !== 32'h0) begin errors++; $display("FAIL rw_rdata got %h exp %h", oReadData, 32'h0); end
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL rw_ovalid got %h exp %h", ovalid, 1'b1); end
  endtask

  task automatic test_branch();
    ivalid = 1'b1; iBranch = 1'b1; iZero = 1'b1; iinvertzero = 1'b1; inextPCBranch = 32'h0000_0040;
    @(negedge clock);
    checks++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL br_inv got %h exp %h", pcsrc, 1'b0); end
    iinvertzero = 1'b0;
    #1;
    checks++; if (pcsrc !== 1'b1) begin errors++; $display("FAIL br_taken got %h exp %h", pcsrc, 1'b1); end
    checks++; if (pcTarget !== 32'h0000_0040) begin errors++; $display("FAIL br_target got %h exp %h", pcTarget, 32'h0000_0040); end
    iBranch = 1'b0; iJump = 1'b1; ivalid = 1'b0;
    #1;
    checks++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL jump_invalid got %h exp %h", pcsrc, 1'b0); end
    ivalid = 1'b1;
    #1;
    checks++; if (pcsrc !== 1'b1) begin errors++; $display("FAIL jump_valid got %h exp %h", pcsrc, 1'b1); end
    step();
    clear_inputs();
  endtask

  task automatic test_ack_idle();
    ivalid = 1'b1; iRegWrite = 1'b1; iResult = 32'h0000_0005;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h0000_1111;
    step();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (oReadData !== 32'h0) begin errors++; $display("FAIL ackidle_rdata got %h exp %h", oReadData, 32'h0); end
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL ackidle_ovalid got %h exp %h", ovalid, 1'b1); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ackidle_req got %h exp %h", dmem_bus.dmem_req, 1'b0); end
  endtask

  task automatic test_reset_access();
    ivalid = 1'b1; iMemRead = 1'b1; iRegWrite = 1'b1; iResult = 32'h0000_0200; iwriteRegWire = 5'd9;
    step();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h0000_CAFE;
    @(negedge clock);
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rstacc_req got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstacc_stall got %h exp %h", stall, 1'b0); end
    step();
    dmem_bus.dmem_ack = 1'b0;
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rstacc_ovalid got %h exp %h", ovalid, 1'b0); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL rstacc_regwrite got %h exp %h", oRegWrite, 1'b0); end
    checks++; if (oReadData !== 32'h0) begin errors++; $display("FAIL rstacc_rdata got %h exp %h", oReadData, 32'h0); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rstacc_req2 got %h exp %h", dmem_bus.dmem_req, 1'b0); end
  endtask

  task automatic test_misalign();
    ivalid = 1'b1; iMemRead = 1'b1; iRegWrite = 1'b1; iResult = 32'h0000_0102;
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clock);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %h exp %h", stall, 1'b0); end
    step();
    clear_inputs();
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %h exp %h", dmem_bus.dmem_req, 1'b0); end
    checks++; if (omisalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %h exp %h", omisalign, 1'b1); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL mis_regwrite got %h exp %h", oRegWrite, 1'b0); end
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL mis_ovalid got %h exp %h", ovalid, 1'b1); end
    step();
    checks++; if (omisalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %h exp %h", omisalign, 1'b0); end
`else
    step();
    checks++; if (dmem_bus.dmem_addr !== 32'h0000_0102) begin errors++; $display("FAIL unal_addr got %h exp %h", dmem_bus.dmem_addr, 32'h0000_0102); end
    checks++; if (omisalign !== 1'b0) begin errors++; $display("FAIL unal_pulse got %h exp %h", omisalign, 1'b0); end
    dmem_bus.dmem_ack = 1'b1;
    step();
    dmem_bus.dmem_ack = 1'b0;
    clear_inputs();
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL unal_ovalid got %h exp %h", ovalid, 1'b1); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_load();
    test_store_back_to_back();
    test_rw_both();
    test_branch();
    test_ack_idle();
    test_reset_access();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
